// File: rtl/video_timing_pkg.sv
// Shared raster-timing types, default 640x480 timing constants and helpers
// used by the timing generator and by the sync delay line.
package video_timing_pkg;

  typedef enum logic [1:0] {
    StActive,
    StFront,
    StSync,
    StBack
  } phase_e;

  localparam int unsigned DefHVisible   = 640;
  localparam int unsigned DefHFront     = 16;
  localparam int unsigned DefHSync      = 96;
  localparam int unsigned DefHBack      = 48;
  localparam int unsigned DefVVisible   = 480;
  localparam int unsigned DefVFront     = 10;
  localparam int unsigned DefVSync      = 2;
  localparam int unsigned DefVBack      = 33;
  localparam int unsigned DefPixelDelay = 8;

  function automatic int unsigned timing_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
    return visible + front + sync + back;
  endfunction

  // Successor phase, skipping any phase whose length is zero.
  function automatic phase_e phase_next(input phase_e      cur,
                                        input int unsigned front,
                                        input int unsigned sync,
                                        input int unsigned back);
    phase_e nxt;
    case (cur)
      StActive: nxt = StFront;
      StFront:  nxt = StSync;
      StSync:   nxt = StBack;
      default:  nxt = StActive;
    endcase
    if (nxt == StFront && front == 0) nxt = StSync;
    if (nxt == StSync && sync == 0) nxt = StBack;
    if (nxt == StBack && back == 0) nxt = StActive;
    return nxt;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Resettable Depth-deep, 3-bit register chain whose output is held at an idle
// value until Depth cycles have elapsed since reset release.
module sync_delay_line
  import video_timing_pkg::*;
#(
  parameter int unsigned Depth     = DefPixelDelay,
  parameter logic [2:0]  IdleValue = 3'b110
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] din,
  output logic [2:0] dout
);

  localparam int unsigned WarmW = $clog2(Depth + 1);

  logic [WarmW-1:0]   warm_q, warm_d;
  logic [3*Depth-1:0] sr_q, sr_d;
  logic [3*Depth+2:0] taps;
  logic               warm_ok;

  always_comb begin
    taps    = {sr_q, din};
    // The value entering the last stage is post-reset data once warm_q reaches Depth-1.
    warm_ok = (warm_q >= WarmW'(Depth - 1));
    warm_d  = (warm_q == WarmW'(Depth)) ? warm_q : warm_q + 1'b1;
    sr_d    = taps[3*Depth-1:0];
    if (!warm_ok) begin
      sr_d[3*Depth-1 -: 3] = IdleValue;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      warm_q <= '0;
      sr_q   <= {Depth{IdleValue}};
    end else begin
      warm_q <= warm_d;
      sr_q   <= sr_d;
    end
  end

  assign dout = taps[3*Depth +: 3];

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel counters, horizontal/vertical phase FSMs, and
// sync/data-enable outputs delayed to line up with the layers' colour output.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE     = DefHVisible,
  parameter int unsigned H_FRONT       = DefHFront,
  parameter int unsigned H_SYNC        = DefHSync,
  parameter int unsigned H_BACK        = DefHBack,
  parameter int unsigned V_VISIBLE     = DefVVisible,
  parameter int unsigned V_FRONT       = DefVFront,
  parameter int unsigned V_SYNC        = DefVSync,
  parameter int unsigned V_BACK        = DefVBack,
  parameter bit          H_SYNC_ACTIVE = 1'b0,
  parameter bit          V_SYNC_ACTIVE = 1'b0,
  parameter int unsigned PIXEL_DELAY   = DefPixelDelay
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [31:0] count_h,
  output logic signed [31:0] count_v,
  output logic               active,
  output logic               line_start,
  output logic               frame_start,
  output logic               vblank,
  output logic               hsync,
  output logic               vsync,
  output logic               de
);

  localparam int unsigned HTotal = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned VTotal = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HW     = $clog2(HTotal);
  localparam int unsigned VW     = $clog2(VTotal);
  localparam int unsigned CntW   = (HW > VW) ? HW : VW;

  // Last count value of each phase.
  localparam logic [CntW-1:0] HEndActive = CntW'(H_VISIBLE - 1);
  localparam logic [CntW-1:0] HEndFront  = CntW'(H_VISIBLE + H_FRONT - 1);
  localparam logic [CntW-1:0] HEndSync   = CntW'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CntW-1:0] HEndBack   = CntW'(HTotal - 1);
  localparam logic [CntW-1:0] VEndActive = CntW'(V_VISIBLE - 1);
  localparam logic [CntW-1:0] VEndFront  = CntW'(V_VISIBLE + V_FRONT - 1);
  localparam logic [CntW-1:0] VEndSync   = CntW'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CntW-1:0] VEndBack   = CntW'(VTotal - 1);
  localparam logic [CntW-1:0] VVisCnt    = CntW'(V_VISIBLE);

  localparam logic [2:0] SyncIdle = {~V_SYNC_ACTIVE, ~H_SYNC_ACTIVE, 1'b0};

  phase_e          h_state_q, h_state_d, v_state_q, v_state_d;
  logic [CntW-1:0] count_h_q, count_h_d, count_v_q, count_v_d;
  logic            active_q, active_d;
  logic            line_start_q, line_start_d;
  logic            frame_start_q, frame_start_d;
  logic            vblank_q, vblank_d;
  logic            h_end, v_end, h_wrap, v_wrap;
  logic [2:0]      raw_sync, dly_sync;

  always_comb begin
    h_end = 1'b0;
    case (h_state_q)
      StActive: h_end = (count_h_q == HEndActive);
      StFront:  h_end = (count_h_q == HEndFront);
      StSync:   h_end = (count_h_q == HEndSync);
      default:  h_end = (count_h_q == HEndBack);
    endcase
    v_end = 1'b0;
    case (v_state_q)
      StActive: v_end = (count_v_q == VEndActive);
      StFront:  v_end = (count_v_q == VEndFront);
      StSync:   v_end = (count_v_q == VEndSync);
      default:  v_end = (count_v_q == VEndBack);
    endcase
  end

  always_comb begin
    h_wrap    = (count_h_q == HEndBack);
    v_wrap    = (count_v_q == VEndBack);
    count_h_d = h_wrap ? '0 : count_h_q + 1'b1;
    h_state_d = h_end ? phase_next(h_state_q, H_FRONT, H_SYNC, H_BACK) : h_state_q;
    count_v_d = count_v_q;
    v_state_d = v_state_q;
    if (h_wrap) begin
      count_v_d = v_wrap ? '0 : count_v_q + 1'b1;
      if (v_end) begin
        v_state_d = phase_next(v_state_q, V_FRONT, V_SYNC, V_BACK);
      end
    end
    active_d      = (h_state_d == StActive) && (v_state_d == StActive);
    line_start_d  = (count_h_d == '0);
    frame_start_d = (count_h_d == '0) && (count_v_d == '0);
    vblank_d      = (count_v_d >= VVisCnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_state_q     <= StActive;
      v_state_q     <= StActive;
      count_h_q     <= '0;
      count_v_q     <= '0;
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
      vblank_q      <= 1'b0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      count_h_q     <= count_h_d;
      count_v_q     <= count_v_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  // Raw conditions of the pixel currently on the counters, as output levels.
  always_comb begin
    raw_sync[2] = (v_state_q == StSync) ? V_SYNC_ACTIVE : ~V_SYNC_ACTIVE;
    raw_sync[1] = (h_state_q == StSync) ? H_SYNC_ACTIVE : ~H_SYNC_ACTIVE;
    raw_sync[0] = active_q;
  end

  sync_delay_line #(
    .Depth    (PIXEL_DELAY),
    .IdleValue(SyncIdle)
  ) u_sync_delay_line (
    .clk  (clk),
    .reset(reset),
    .din  (raw_sync),
    .dout (dly_sync)
  );

  assign count_h     = $signed({{(32 - CntW){1'b0}}, count_h_q});
  assign count_v     = $signed({{(32 - CntW){1'b0}}, count_v_q});
  assign active      = active_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vblank      = vblank_q;
  assign vsync       = dly_sync[2];
  assign hsync       = dly_sync[1];
  assign de          = dly_sync[0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four parameterisations checked every cycle against
// an arithmetic raster model, with random reset pulses and pinned literal checks.
module tb_video_timing_gen;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb, pd;
    bit hp, vp;
  } tp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  logic signed [31:0] ch_a, cv_a, ch_b, cv_b, ch_c, cv_c, ch_d, cv_d;
  logic act_a, ls_a, fs_a, vb_a, hs_a, vs_a, de_a;
  logic act_b, ls_b, fs_b, vb_b, hs_b, vs_b, de_b;
  logic act_c, ls_c, fs_c, vb_c, hs_c, vs_c, de_c;
  logic act_d, ls_d, fs_d, vb_d, hs_d, vs_d, de_d;

  // Default 640x480 timing.
  video_timing_gen u_dut_a (
    .clk(clk), .reset(reset), .count_h(ch_a), .count_v(cv_a), .active(act_a),
    .line_start(ls_a), .frame_start(fs_a), .vblank(vb_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a)
  );

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIXEL_DELAY(2)
  ) u_dut_b (
    .clk(clk), .reset(reset), .count_h(ch_b), .count_v(cv_b), .active(act_b),
    .line_start(ls_b), .frame_start(fs_b), .vblank(vb_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b)
  );

  video_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(0), .H_SYNC(96), .H_BACK(0),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .PIXEL_DELAY(3)
  ) u_dut_c (
    .clk(clk), .reset(reset), .count_h(ch_c), .count_v(cv_c), .active(act_c),
    .line_start(ls_c), .frame_start(fs_c), .vblank(vb_c), .hsync(hs_c), .vsync(vs_c),
    .de(de_c)
  );

  video_timing_gen #(
    .H_VISIBLE(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
    .V_VISIBLE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .H_SYNC_ACTIVE(1'b1), .V_SYNC_ACTIVE(1'b1), .PIXEL_DELAY(4)
  ) u_dut_d (
    .clk(clk), .reset(reset), .count_h(ch_d), .count_v(cv_d), .active(act_d),
    .line_start(ls_d), .frame_start(fs_d), .vblank(vb_d), .hsync(hs_d), .vsync(vs_d),
    .de(de_d)
  );

  task automatic chk(input string tag, input string sig, input int t,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) begin
        $display("FAIL %s.%s t=%0d got=%0d expected=%0d", tag, sig, t, act, exp);
      end
    end
  endtask

  task automatic chkb(input string tag, input string sig, input int t,
                      input logic act, input logic exp);
    chk(tag, sig, t, {31'b0, act}, {31'b0, exp});
  endtask

  // Expected outputs t cycles after the last reset edge, from raster arithmetic.
  task automatic cmp(input string tag, input tp_t p, input int t,
                     input logic [31:0] ch, input logic [31:0] cv,
                     input logic act, input logic ls, input logic fs, input logic vb,
                     input logic hs, input logic vs, input logic de);
    int ht, vt, h, v, tt, dh, dv;
    logic e_de, e_hs, e_vs;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vs + p.vb;
    h  = t % ht;
    v  = (t / ht) % vt;
    chk(tag, "count_h", t, ch, 32'(h));
    chk(tag, "count_v", t, cv, 32'(v));
    chkb(tag, "active", t, act, (h < p.hv) && (v < p.vv));
    chkb(tag, "line_start", t, ls, h == 0);
    chkb(tag, "frame_start", t, fs, (h == 0) && (v == 0));
    chkb(tag, "vblank", t, vb, v >= p.vv);
    if (t < p.pd) begin
      e_de = 1'b0;
      e_hs = ~p.hp;
      e_vs = ~p.vp;
    end else begin
      tt   = t - p.pd;
      dh   = tt % ht;
      dv   = (tt / ht) % vt;
      e_de = (dh < p.hv) && (dv < p.vv);
      e_hs = (dh >= p.hv + p.hf && dh < p.hv + p.hf + p.hs) ? p.hp : ~p.hp;
      e_vs = (dv >= p.vv + p.vf && dv < p.vv + p.vf + p.vs) ? p.vp : ~p.vp;
    end
    chkb(tag, "de", t, de, e_de);
    chkb(tag, "hsync", t, hs, e_hs);
    chkb(tag, "vsync", t, vs, e_vs);
  endtask

  initial begin : compare
    tp_t pa, pb, pc, pd;
    int t;
    logic r;
    pa = '{640, 16, 96, 48, 480, 10, 2, 33, 8, 1'b0, 1'b0};
    pb = '{4, 1, 1, 1, 2, 1, 1, 1, 2, 1'b0, 1'b0};
    pc = '{640, 0, 96, 0, 4, 1, 1, 1, 3, 1'b0, 1'b0};
    pd = '{20, 3, 4, 5, 12, 2, 2, 3, 4, 1'b1, 1'b1};
    t = 0;
    forever begin
      @(posedge clk);
      r = reset;
      @(negedge clk);
      if (r) t = 0;
      else t++;
      cmp("a", pa, t, ch_a, cv_a, act_a, ls_a, fs_a, vb_a, hs_a, vs_a, de_a);
      cmp("b", pb, t, ch_b, cv_b, act_b, ls_b, fs_b, vb_b, hs_b, vs_b, de_b);
      cmp("c", pc, t, ch_c, cv_c, act_c, ls_c, fs_c, vb_c, hs_c, vs_c, de_c);
      cmp("d", pd, t, ch_d, cv_d, act_d, ls_d, fs_d, vb_d, hs_d, vs_d, de_d);
    end
  end

  initial begin : stimulus
    int fs_b_at[2];
    int nfs_b, fs_c_at, fs_d_at, vs_d_len, vs_d_first;
    nfs_b = 0;
    fs_c_at = 0;
    fs_d_at = 0;
    vs_d_len = 0;
    vs_d_first = 0;
    fs_b_at[0] = 0;
    fs_b_at[1] = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("a", "count_h@0", 0, ch_a, 32'd0);
    chk("a", "count_v@0", 0, cv_a, 32'd0);
    chkb("a", "frame_start@0", 0, fs_a, 1'b1);
    chkb("a", "active@0", 0, act_a, 1'b1);
    chkb("a", "de@0", 0, de_a, 1'b0);
    chkb("a", "hsync@0", 0, hs_a, 1'b1);
    chkb("d", "hsync@0", 0, hs_d, 1'b0);
    for (int cyc = 1; cyc <= 5200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) chk("a", "count_h@1", cyc, ch_a, 32'd1);
      if (cyc == 7) chkb("a", "de@7", cyc, de_a, 1'b0);
      if (cyc == 8) chkb("a", "de@8", cyc, de_a, 1'b1);
      if (cyc == 663) chkb("a", "hsync@663", cyc, hs_a, 1'b1);
      if (cyc == 664) chkb("a", "hsync@664", cyc, hs_a, 1'b0);
      if (cyc == 759) chkb("a", "hsync@759", cyc, hs_a, 1'b0);
      if (cyc == 760) chkb("a", "hsync@760", cyc, hs_a, 1'b1);
      if (cyc == 799) chk("a", "count_h@799", cyc, ch_a, 32'd799);
      if (cyc == 800) begin
        chk("a", "count_h@800", cyc, ch_a, 32'd0);
        chk("a", "count_v@800", cyc, cv_a, 32'd1);
      end
      if (cyc == 6) chk("b", "count_h@6", cyc, ch_b, 32'd6);
      if (cyc == 7) chk("b", "count_v@7", cyc, cv_b, 32'd1);
      if (cyc == 34) chk("b", "count_v@34", cyc, cv_b, 32'd4);
      if (cyc == 642) chkb("c", "hsync@642", cyc, hs_c, 1'b1);
      if (cyc == 643) chkb("c", "hsync@643", cyc, hs_c, 1'b0);
      if (cyc == 738) chkb("c", "hsync@738", cyc, hs_c, 1'b0);
      if (cyc == 739) chkb("c", "hsync@739", cyc, hs_c, 1'b1);
      if (cyc == 735) chk("c", "count_h@735", cyc, ch_c, 32'd735);
      if (cyc == 736) chk("c", "count_h@736", cyc, ch_c, 32'd0);
      if (fs_b && nfs_b < 2) begin
        fs_b_at[nfs_b] = cyc;
        nfs_b++;
      end
      if (fs_c && fs_c_at == 0) fs_c_at = cyc;
      if (fs_d && fs_d_at == 0) fs_d_at = cyc;
      if (cyc < 608 && vs_d) begin
        vs_d_len++;
        if (vs_d_first == 0) vs_d_first = cyc;
      end
    end
    chk("b", "frame_period1", 0, 32'(fs_b_at[0]), 32'd35);
    chk("b", "frame_period2", 0, 32'(fs_b_at[1]), 32'd70);
    chk("c", "frame_period", 0, 32'(fs_c_at), 32'd5152);
    chk("d", "frame_period", 0, 32'(fs_d_at), 32'd608);
    chk("d", "vsync_len", 0, 32'(vs_d_len), 32'd64);
    chk("d", "vsync_first", 0, 32'(vs_d_first), 32'd452);

    // Random mid-frame reset pulses; the per-cycle model checks recovery.
    for (int seg = 0; seg < 24; seg++) begin
      repeat ($urandom_range(1, 2500)) @(posedge clk);
      #1 reset = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 reset = 1'b0;
    end
    repeat (700) @(posedge clk);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
